// File: rtl/mdu_div_pkg.sv
// Shared encodings for the iterative divider.
package mdu_div_pkg;

  // Result select encoding carried on op_rem
  localparam logic REMAINDER = 1'b1;
  localparam logic QUOTIENT  = 1'b0;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned WORD_W       = 32;

  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivCalc = 2'd1,
    DivDone = 2'd2
  } div_state_e;

endpackage

// File: rtl/mdu_div_iter_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, try the subtract.
module mdu_div_iter_step #(
  parameter int unsigned Width = 32
) (
  input  logic [Width:0]   part_rem,
  input  logic [Width-1:0] divisor,
  input  logic             next_bit,
  output logic [Width:0]   new_rem,
  output logic             q_bit
);

  logic [Width+1:0] shifted;
  logic [Width+1:0] trial;

  // Trial subtract is one bit wider so its MSB is a clean borrow flag
  always_comb begin
    shifted = {part_rem, next_bit};
    trial   = shifted - {2'b00, divisor};
    q_bit   = ~trial[Width+1];
    new_rem = q_bit ? trial[Width:0] : shifted[Width:0];
  end

endmodule

// File: rtl/mdu_div.sv
// Iterative radix-2 signed/unsigned divider with word-op support and valid/ready handshakes.
module mdu_div
  import mdu_div_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter bit          HAS_WORD = (XLEN == 64)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op_sign,
  input  logic            op_rem,
  input  logic            op_word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = 7;

  div_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            word_q;
  logic            rem_sel_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic [XLEN-1:0] dvd_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   prem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] result_q;

  logic            word_in;
  logic [XLEN-1:0] ext_dvd, ext_dvs, min_val, abs_dvd, abs_dvs, special_raw, special_res;
  logic            dvd_neg, dvs_neg, div_zero, ovf;
  logic [XLEN:0]   step_rem;
  logic            step_q;
  logic [XLEN-1:0] quo_final, rem_final, q_fix, r_fix, sel_res, calc_res;
  logic            last_iter;

  // Place a 32-bit value in the low word, extending with its bit 31 when sx is set
  function automatic logic [XLEN-1:0] extend_word(input logic [31:0] v, input logic sx);
    logic [XLEN-1:0] out;
    out       = {XLEN{sx & v[31]}};
    out[31:0] = v;
    return out;
  endfunction

  // Operand conditioning and special-case detection for the accept cycle
  always_comb begin
    word_in = HAS_WORD && (XLEN > WORD_W) && op_word;
    ext_dvd = word_in ? extend_word(dividend[31:0], op_sign) : dividend;
    ext_dvs = word_in ? extend_word(divisor[31:0], op_sign) : divisor;
    min_val = word_in ? extend_word(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
    dvd_neg = op_sign & ext_dvd[XLEN-1];
    dvs_neg = op_sign & ext_dvs[XLEN-1];
    abs_dvd = dvd_neg ? ('0 - ext_dvd) : ext_dvd;
    abs_dvs = dvs_neg ? ('0 - ext_dvs) : ext_dvs;
    div_zero = (ext_dvs == '0);
    ovf      = op_sign && (ext_dvd == min_val) && (ext_dvs == '1);
    if (div_zero) begin
      special_raw = op_rem ? ext_dvd : '1;
    end else begin
      special_raw = op_rem ? '0 : ext_dvd;
    end
    special_res = word_in ? extend_word(special_raw[31:0], 1'b1) : special_raw;
  end

  mdu_div_iter_step #(
    .Width (XLEN)
  ) u_step (
    .part_rem (prem_q),
    .divisor  (dvs_q),
    .next_bit (dvd_q[XLEN-1]),
    .new_rem  (step_rem),
    .q_bit    (step_q)
  );

  // Final-iteration result with sign fix-up and word sign-extension
  always_comb begin
    quo_final = {quo_q[XLEN-2:0], step_q};
    rem_final = step_rem[XLEN-1:0];
    q_fix     = neg_quo_q ? ('0 - quo_final) : quo_final;
    r_fix     = neg_rem_q ? ('0 - rem_final) : rem_final;
    sel_res   = (rem_sel_q == QUOTIENT) ? q_fix : r_fix;
    calc_res  = word_q ? extend_word(sel_res[31:0], 1'b1) : sel_res;
    last_iter = (cnt_q == (word_q ? CntW'(WORD_W - 1) : CntW'(XLEN - 1)));
  end

  // Control FSM, iteration datapath and registered result
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= DivIdle;
      cnt_q     <= '0;
      word_q    <= 1'b0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      prem_q    <= '0;
      quo_q     <= '0;
      result_q  <= '0;
    end else if (flush) begin
      state_q <= DivIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        DivIdle: begin
          if (in_valid) begin
            word_q    <= word_in;
            rem_sel_q <= op_rem;
            neg_quo_q <= dvd_neg ^ dvs_neg;
            neg_rem_q <= dvd_neg;
            cnt_q     <= '0;
            prem_q    <= '0;
            quo_q     <= '0;
            // Word dividends are left-aligned so the next bit is always the MSB
            dvd_q     <= word_in ? (abs_dvd << (XLEN - WORD_W)) : abs_dvd;
            dvs_q     <= abs_dvs;
            if (div_zero || ovf) begin
              result_q <= special_res;
              state_q  <= DivDone;
            end else begin
              state_q <= DivCalc;
            end
          end
        end
        DivCalc: begin
          prem_q <= step_rem;
          quo_q  <= quo_final;
          dvd_q  <= dvd_q << 1;
          cnt_q  <= cnt_q + CntW'(1);
          if (last_iter) begin
            result_q <= calc_res;
            cnt_q    <= '0;
            state_q  <= DivDone;
          end
        end
        DivDone: begin
          if (out_ready) begin
            state_q <= DivIdle;
          end
        end
        default: state_q <= DivIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == DivIdle);
  assign out_valid = (state_q == DivDone);
  assign result    = result_q;

endmodule

// File: tb/tb_mdu_div.sv
// Directed bench for mdu_div: a 32-bit and a 64-bit instance checked against a behavioural model.
module tb_mdu_div;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush;
  logic iv32, ir32, s32, rm32, w32, ov32, or32;
  logic [31:0] a32, b32, res32;
  logic iv64, ir64, s64, rm64, w64, ov64, or64;
  logic [63:0] a64, b64, res64;

  logic [63:0] exp32, exp64;
  int n_checks = 0;
  int n_fail   = 0;

  mdu_div #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst), .flush(flush), .in_valid(iv32), .in_ready(ir32),
    .op_sign(s32), .op_rem(rm32), .op_word(w32), .dividend(a32), .divisor(b32),
    .out_valid(ov32), .out_ready(or32), .result(res32)
  );

  mdu_div #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst), .flush(flush), .in_valid(iv64), .in_ready(ir64),
    .op_sign(s64), .op_rem(rm64), .op_word(w64), .dividend(a64), .divisor(b64),
    .out_valid(ov64), .out_ready(or64), .result(res64)
  );

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, wanted %h", name, act, req);
    end
  endtask

  // RISC-V division semantics computed with plain arithmetic
  function automatic logic [63:0] model(input int xlen, input bit sgn, input bit rem,
                                        input bit word, input logic [63:0] a,
                                        input logic [63:0] b);
    int w;
    logic [63:0] m, ua, ub, r;
    longint sa, sb;
    w  = word ? 32 : xlen;
    m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    ua = a & m;
    ub = b & m;
    if (w == 32) begin
      sa = longint'($signed(ua[31:0]));
      sb = longint'($signed(ub[31:0]));
    end else begin
      sa = $signed(ua);
      sb = $signed(ub);
    end
    if (ub == 64'd0) r = rem ? ua : m;
    else if (sgn && sb == -64'sd1) r = rem ? 64'd0 : (64'd0 - ua);
    else if (sgn) r = rem ? 64'(sa % sb) : 64'(sa / sb);
    else r = rem ? (ua % ub) : (ua / ub);
    r = r & m;
    if (word && xlen == 64 && r[31]) r = r | ~m;
    return r;
  endfunction

  // Per-edge snapshot used to detect result changes while held under backpressure
  logic pv32, phs32, pv64, phs64;
  logic [31:0] pres32;
  logic [63:0] pres64;
  always @(posedge clk) begin
    pv32 = ov32; phs32 = ov32 & or32; pres32 = res32;
    pv64 = ov64; phs64 = ov64 & or64; pres64 = res64;
  end

  // Compare process: whenever a result is presented it must match the model and be stable
  always @(negedge clk) begin
    if (!rst) begin
      if (ov32) begin
        chk(res32 == exp32[31:0], "cmp32 result", {32'h0, res32}, exp32);
        if (pv32 && !phs32) chk(res32 == pres32, "cmp32 stable", {32'h0, res32}, {32'h0, pres32});
      end
      if (ov64) begin
        chk(res64 == exp64, "cmp64 result", res64, exp64);
        if (pv64 && !phs64) chk(res64 == pres64, "cmp64 stable", res64, pres64);
      end
    end
  end

  task automatic run_op(input bit big, input bit sgn, input bit rem, input bit word,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp_lit,
                        input int lat, input int hold, input string name);
    int n;
    logic valid;
    logic [63:0] got, mexp, want;
    mexp = model(big ? 64 : 32, sgn, rem, word, a, b);
    want = big ? exp_lit : {32'h0, exp_lit[31:0]};
    chk(mexp == want, {name, " model"}, mexp, want);
    @(negedge clk);
    if (big) begin
      exp64 = mexp; iv64 = 1'b1; s64 = sgn; rm64 = rem; w64 = word; a64 = a; b64 = b;
    end else begin
      exp32 = mexp; iv32 = 1'b1; s32 = sgn; rm32 = rem; w32 = word;
      a32 = a[31:0]; b32 = b[31:0];
    end
    @(posedge clk);
    #1;
    iv32 = 1'b0;
    iv64 = 1'b0;
    n = 0;
    valid = 1'b0;
    while (!valid && n < 200) begin
      @(negedge clk);
      n++;
      valid = big ? ov64 : ov32;
    end
    chk(n == lat, {name, " latency"}, 64'(n), 64'(lat));
    got = big ? res64 : {32'h0, res32};
    chk(got == want, {name, " result"}, got, want);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      valid = big ? ov64 : ov32;
      chk(valid, {name, " held valid"}, 64'(valid), 64'd1);
    end
    if (big) or64 = 1'b1; else or32 = 1'b1;
    @(posedge clk);
    #1;
    or32 = 1'b0;
    or64 = 1'b0;
    valid = big ? (ir64 & ~ov64) : (ir32 & ~ov32);
    chk(valid, {name, " release"}, 64'(valid), 64'd1);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; flush = 1'b0;
    iv32 = 0; s32 = 0; rm32 = 0; w32 = 0; or32 = 0; a32 = '0; b32 = '0;
    iv64 = 0; s64 = 0; rm64 = 0; w64 = 0; or64 = 0; a64 = '0; b64 = '0;
    exp32 = '0; exp64 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk(ir32 == 1'b1, "reset in_ready32", 64'(ir32), 64'd1);
    chk(ov32 == 1'b0, "reset out_valid32", 64'(ov32), 64'd0);
    chk(res32 == 32'h0, "reset result32", {32'h0, res32}, 64'd0);
    chk(ir64 == 1'b1 && ov64 == 1'b0, "reset handshake64", {ir64, ov64}, 64'd2);
    chk(res64 == 64'h0, "reset result64", res64, 64'd0);

    // XLEN=32 directed vectors
    run_op(0, 0, 0, 0, 64'd20, 64'd3, 64'd6, 33, 0, "divu 20/3");
    run_op(0, 0, 1, 0, 64'd20, 64'd3, 64'd2, 33, 0, "remu 20/3");
    run_op(0, 1, 0, 0, 64'hFFFF_FFEC, 64'd3, 64'hFFFF_FFFA, 33, 0, "div -20/3");
    run_op(0, 1, 1, 0, 64'hFFFF_FFEC, 64'd3, 64'hFFFF_FFFE, 33, 0, "rem -20/3");
    run_op(0, 1, 0, 0, 64'd7, 64'hFFFF_FFFE, 64'hFFFF_FFFD, 33, 0, "div 7/-2");
    run_op(0, 1, 1, 0, 64'd7, 64'hFFFF_FFFE, 64'd1, 33, 0, "rem 7/-2");
    run_op(0, 0, 0, 0, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF, 33, 0, "divu max/1");
    run_op(0, 0, 0, 0, 64'd7, 64'd0, 64'hFFFF_FFFF, 1, 0, "divu 7/0");
    run_op(0, 0, 1, 0, 64'd7, 64'd0, 64'd7, 1, 0, "remu 7/0");
    run_op(0, 1, 0, 0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1, 0, "div ovf");
    run_op(0, 1, 1, 0, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1, 0, "rem ovf");

    // Flush mid-calculation at cycle 10; in_valid during the flush cycle is ignored
    @(negedge clk);
    exp32 = model(32, 0, 0, 0, 64'd20, 64'd3);
    iv32 = 1'b1; s32 = 0; rm32 = 0; a32 = 32'd20; b32 = 32'd3;
    @(posedge clk);
    #1;
    iv32 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    iv32 = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    iv32 = 1'b0;
    @(negedge clk);
    chk(ir32 == 1'b1, "flush in_ready", 64'(ir32), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = seen | ov32;
    end
    chk(!seen, "flush no out_valid", 64'(seen), 64'd0);

    // Backpressure: result held 5 cycles, then released on out_ready
    run_op(0, 0, 0, 0, 64'd100, 64'd7, 64'd14, 33, 5, "divu 100/7 hold");

    // Flush in DONE overrides out_ready
    @(negedge clk);
    exp32 = model(32, 0, 0, 0, 64'd7, 64'd0);
    iv32 = 1'b1; s32 = 0; rm32 = 0; a32 = 32'd7; b32 = 32'd0;
    @(posedge clk);
    #1;
    iv32 = 1'b0;
    @(negedge clk);
    chk(ov32 == 1'b1, "done before flush", 64'(ov32), 64'd1);
    flush = 1'b1;
    or32 = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    or32 = 1'b0;
    chk(ov32 == 1'b0 && ir32 == 1'b1, "flush in done", {ov32, ir32}, 64'd1);

    // XLEN=64 vectors, word and full-width
    run_op(1, 1, 0, 1, 64'h0000_0001_FFFF_FFF0, 64'd4, 64'hFFFF_FFFF_FFFF_FFFC, 33, 0, "divw");
    run_op(1, 0, 0, 0, 64'h0000_0001_FFFF_FFF0, 64'd4, 64'h0000_0000_7FFF_FFFC, 65, 0, "divu64");
    run_op(1, 0, 0, 1, 64'h0000_0001_FFFF_FFF0, 64'd4, 64'h0000_0000_3FFF_FFFC, 33, 0, "divuw");
    run_op(1, 1, 1, 1, 64'h0000_0001_FFFF_FFF0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 33, 2, "remw");
    run_op(1, 1, 0, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1, 0, "div64 ovf");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout, wanted completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_div.md
# mdu_div

Parametrised iterative radix-2 integer divider for the EX stage's multiply/divide unit. It replaces the fixed 32-bit divider, adding several capabilities:
- XLEN parameterisation (32/64).
- RV64 word ops (DIVW/DIVUW/REMW/REMUW).
- A valid/ready handshake on both sides, with the result held under backpressure.
- Single-cycle early-out for divide-by-zero and signed overflow, following RISC-V semantics.

It sits beside the ALU and is stalled or flushed by the pipeline controller.

## Interface
- XLEN, 32, datapath width; legal values 32 and 64.
- HAS_WORD, (XLEN==64), enables the op_word path. When 0, op_word is ignored.
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-high; asserted when rst_n==1 (`DFF_RST_ENABLE`=1'b1).
- flush  in  1  pipeline flush; aborts any operation.
- in_valid  in  1  operation request.
- in_ready  out  1  divider can accept a request.
- op_sign  in  1  1 = signed (DIV/REM), 0 = unsigned.
- op_rem  in  1  1 = return remainder, 0 = return quotient (`REMAINDER` encoding).
- op_word  in  1  32-bit word op; result is sign-extended to XLEN.
- dividend  in  XLEN  rs1 value.
- divisor  in  XLEN  rs2 value.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  quotient or remainder.

## Operation
- FSM states: IDLE, CALC, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- Accept: when in_valid && in_ready, latch operands and op fields.
  - Effective width W = 32 if op_word, else XLEN.
  - In word mode, operands are the low 32 bits, sign-extended if op_sign, else zero-extended.
- Special cases are decided at accept, and go IDLE→DONE with no iterations:
  - divisor==0: quotient = all-ones (W bits); remainder = dividend.
  - Signed, dividend==−2^(W−1), divisor==−1: quotient = dividend; remainder = 0.
- Normal path:
  - Take absolute values when signed.
  - Remainder register is W+1 bits; quotient shift register is W bits.
  - Run W iterations of restoring shift-subtract, one quotient bit per cycle, MSB first.
  - Iteration counter counts 0..W−1.
- Sign fix-up (signed only):
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Fix-up is computed on the CALC→DONE transition and registered into result.
- Word mode: the 32-bit result is sign-extended to XLEN for both signed and unsigned variants.
- DONE: result is held stable while out_valid && !out_ready. DONE→IDLE on out_ready.
- Flush:
  - Any state → IDLE on the next edge. out_valid deasserts; the counter clears.
  - in_valid in the flush cycle is ignored.
  - Flush overrides out_ready and accept in the same cycle.
- Reset: state=IDLE, counter=0, result=0, out_valid=0, in_ready=1 from the first post-reset cycle.

## Timing
- Cycle 0 = accept edge.
  - Normal ops: out_valid rises at cycle W+1 (33 for 32-bit, 65 for 64-bit).
  - Special cases: out_valid rises at cycle 1.
- No new accept while busy. in_ready rises the cycle after the out_valid&&out_ready handshake, so back-to-back throughput is W+2 cycles.
- No combinational path from in_valid to out_valid, or from out_ready to in_ready.

## Structure
- Shared in defines.v:
  - `REMAINDER`/`QUOTIENT` encodings.
  - DIV_IDLE/DIV_CALC/DIV_DONE state encodings.
  - `XLEN` default.
- Sub-module div_iter_step: combinational single-step restoring subtract, parametrised by width. Inputs are partial remainder, divisor, and next dividend bit; outputs are new partial remainder and quotient bit.
- Top: FSM, counter, operand latch, special-case detect, sign fix-up, output register.

## Test plan
- Unsigned divide (XLEN=32): 20 / 3.
  - op_rem=0: result=6 at cycle 33.
  - Repeat with op_rem=1: result=2.
- Signed divide (XLEN=32): −20 / 3, i.e. 0xFFFFFFEC / 3.
  - Quotient: 0xFFFFFFFA.
  - Remainder: 0xFFFFFFFE.
  - Both at cycle 33.
- Divide by zero: 7 / 0.
  - Quotient 0xFFFFFFFF at cycle 1.
  - Remainder 7 at cycle 1.
- Signed overflow: 0x80000000 / 0xFFFFFFFF.
  - Quotient 0x80000000 at cycle 1.
  - Remainder 0 at cycle 1.
- Flush and backpressure:
  - Flush at cycle 10: out_valid is never asserted, and in_ready=1 at cycle 11.
  - A new 100 / 7 then yields 14.
  - With out_ready held low 5 cycles after out_valid, result stays stable and completes on the first out_ready.
- Word mode (XLEN=64, DIVW): dividend=0x00000001_FFFFFFF0 (low word −16), divisor=0x00000000_00000004.
  - result=0xFFFFFFFF_FFFFFFFC at cycle 33.
  - 64-bit DIVU of the same operands: result=0x00000000_7FFFFFFC at cycle 65.
